// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg
//   Shared constants and types for the memory/IO responder slice:
//   default widths, the IO window decode bits, IO register addresses,
//   and a helper that maps an 18-bit IO address onto a register select.
//   Imported by mem_io_responder and mem_io_tx_fifo.
package mem_io_responder_pkg;

  localparam int DEF_RAM_ADDR_WIDTH = 17;  // 128 KB of byte RAM
  localparam int DEF_TX_FIFO_DEPTH  = 16;

  // IO window: address bits [17:16] == 2'b11 select IO instead of RAM.
  localparam int         IO_SEL_HI  = 17;
  localparam int         IO_SEL_LO  = 16;
  localparam logic [1:0] IO_SEL_VAL = 2'b11;

  localparam logic [17:0] IO_TXRX_ADDR     = 18'h30000;  // UART TX write / RX read
  localparam logic [17:0] IO_HALT_CNT_ADDR = 18'h30004;  // halt write / counter byte 0 read

  typedef enum logic [2:0] {
    IO_REG_NONE,
    IO_REG_TXRX,
    IO_REG_HALT_CNT0,
    IO_REG_CNT1,
    IO_REG_CNT2,
    IO_REG_CNT3
  } io_reg_e;

  function automatic io_reg_e io_decode(input logic [17:0] addr);
    io_reg_e sel;
    sel = IO_REG_NONE;
    case (addr)
      IO_TXRX_ADDR:             sel = IO_REG_TXRX;
      IO_HALT_CNT_ADDR:         sel = IO_REG_HALT_CNT0;
      IO_HALT_CNT_ADDR + 18'd1: sel = IO_REG_CNT1;
      IO_HALT_CNT_ADDR + 18'd2: sel = IO_REG_CNT2;
      IO_HALT_CNT_ADDR + 18'd3: sel = IO_REG_CNT3;
      default:                  sel = IO_REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if
//   Bundles the CPU memory bus and the UART TX/RX byte streams seen by
//   mem_io_responder. Signal names keep their _in/_out suffixes as seen
//   from the responder.
//   Modports: master (CPU / UART side, drives the *_in signals)
//             slave  (responder, drives the *_out signals)
interface mem_io_responder_if;
  logic [31:0] mem_a_in;
  logic        mem_wr_in;
  logic [7:0]  mem_dout_in;
  logic [7:0]  mem_din_out;
  logic        io_buffer_full_out;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic        rx_pop_out;
  logic        halt_out;

  modport master (
    output mem_a_in, mem_wr_in, mem_dout_in, tx_ready_in, rx_data_in, rx_valid_in,
    input  mem_din_out, io_buffer_full_out, tx_data_out, tx_valid_out, rx_pop_out, halt_out
  );

  modport slave (
    input  mem_a_in, mem_wr_in, mem_dout_in, tx_ready_in, rx_data_in, rx_valid_in,
    output mem_din_out, io_buffer_full_out, tx_data_out, tx_valid_out, rx_pop_out, halt_out
  );
endinterface

// File: rtl/mem_io_tx_fifo.sv
// mem_io_tx_fifo
//   Byte FIFO feeding the UART transmitter. Pointers carry one extra wrap
//   bit so full and empty are distinguishable without a separate counter.
//   A push while full is accepted only when a pop happens in the same cycle.
//   Ports: clk_in, rst_in (async, active-low), push/wdata, pop,
//          rdata (combinational head), full, empty, count.
module mem_io_tx_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage is deliberately left out of reset; only the pointers
  // define what is valid, and a resettable array would cost a reset fan-out
  // per bit for no behavioural gain.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Answers CPU byte accesses: RAM below the IO window, and a small set of
//   IO registers at 0x30000 (UART TX push / RX pop) and 0x30004..7
//   (halt on write, cycle-counter snapshot bytes on read).
//   Reads return on the registered mem_din_out one cycle after the access.
//   Ports: clk_in, rst_in (async, active-low), bus (mem_io_responder_if.slave).
//   Optional feature: define MEM_IO_CYCLE_CNT_EN to build the 32-bit cycle
//   counter and its snapshot; otherwise 0x30004..7 read as 0x00.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
  parameter int TX_FIFO_DEPTH  = DEF_TX_FIFO_DEPTH
) (
  input logic                clk_in,
  input logic                rst_in,
  mem_io_responder_if.slave  bus
);

  localparam int               FIFO_AW      = $clog2(TX_FIFO_DEPTH);
  // Raise the nearly-full flag with two slots of slack for in-flight writes.
  localparam logic [FIFO_AW:0] BUF_FULL_LVL = (FIFO_AW + 1)'(TX_FIFO_DEPTH - 2);

  logic [7:0] ram [2**RAM_ADDR_WIDTH];

  logic [17:0]               dec_addr;
  logic [RAM_ADDR_WIDTH-1:0] ram_idx;
  logic                      is_io;
  io_reg_e                   io_reg;
  logic                      wr_ok;
  logic                      rd_en;
  logic                      ram_we;
  logic                      halt_hit;
  logic                      tx_push;
  logic [7:0]                tx_wdata;
  logic                      rx_take;
  logic [7:0]                io_rdata;

  logic [7:0]       din_q;
  logic             rx_pop_q;
  logic             halt_q;
  logic             buf_full_q;

  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic             push_acc;
  logic             pop_acc;
  logic [FIFO_AW:0] fifo_count_next;

  logic             unused_addr_bits;
  assign unused_addr_bits = ^bus.mem_a_in[31:18];

  assign dec_addr = bus.mem_a_in[17:0];
  assign ram_idx  = bus.mem_a_in[RAM_ADDR_WIDTH-1:0];
  assign is_io    = (dec_addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL_VAL);
  assign io_reg   = is_io ? io_decode(dec_addr) : IO_REG_NONE;

  // Once halted, every write (RAM or IO) is dropped; reads keep working.
  assign wr_ok    = bus.mem_wr_in && !halt_q;
  assign rd_en    = !bus.mem_wr_in;
  assign ram_we   = wr_ok && !is_io;
  assign halt_hit = wr_ok && (io_reg == IO_REG_HALT_CNT0);
  assign tx_push  = halt_hit || (wr_ok && (io_reg == IO_REG_TXRX) && (bus.mem_dout_in != 8'h00));
  assign tx_wdata = halt_hit ? 8'h00 : bus.mem_dout_in;
  assign rx_take  = rd_en && (io_reg == IO_REG_TXRX) && bus.rx_valid_in;

  // Mirror the FIFO's acceptance rule to know the post-edge occupancy.
  assign pop_acc         = bus.tx_ready_in && !fifo_empty;
  assign push_acc        = tx_push && (!fifo_full || pop_acc);
  assign fifo_count_next = fifo_count + (FIFO_AW + 1)'(push_acc) - (FIFO_AW + 1)'(pop_acc);

  mem_io_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push),
    .wdata  (tx_wdata),
    .pop    (bus.tx_ready_in),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

`ifdef MEM_IO_CYCLE_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] cnt_snap;

  // Reading byte 0 freezes the whole value so bytes 1..3 read on later
  // cycles belong to the same sample.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt <= '0;
      cnt_snap  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (rd_en && (io_reg == IO_REG_HALT_CNT0)) cnt_snap <= cycle_cnt;
    end
  end
`endif

  // NOTE: io_rdata gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    io_rdata = 8'h00;
    case (io_reg)
      IO_REG_TXRX:      if (bus.rx_valid_in) io_rdata = bus.rx_data_in;
`ifdef MEM_IO_CYCLE_CNT_EN
      IO_REG_HALT_CNT0: io_rdata = cycle_cnt[7:0];
      IO_REG_CNT1:      io_rdata = cnt_snap[15:8];
      IO_REG_CNT2:      io_rdata = cnt_snap[23:16];
      IO_REG_CNT3:      io_rdata = cnt_snap[31:24];
`endif
      default:          io_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_idx] <= bus.mem_dout_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      din_q      <= 8'h00;
      rx_pop_q   <= 1'b0;
      halt_q     <= 1'b0;
      buf_full_q <= 1'b0;
    end else begin
      rx_pop_q   <= rx_take;
      buf_full_q <= (fifo_count_next >= BUF_FULL_LVL);
      if (halt_hit) halt_q <= 1'b1;
      if (rd_en)    din_q  <= is_io ? io_rdata : ram[ram_idx];
    end
  end

  assign bus.mem_din_out        = din_q;
  assign bus.rx_pop_out         = rx_pop_q;
  assign bus.halt_out           = halt_q;
  assign bus.io_buffer_full_out = buf_full_q;
  assign bus.tx_data_out        = fifo_rdata;
  assign bus.tx_valid_out       = !fifo_empty;

endmodule

// File: doc/mem_io_responder.md
MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 17, giving the RAM byte-address width (128 KB).
REQ-002 SHALL have parameter TX_FIFO_DEPTH, default 16, giving the UART TX FIFO depth in bytes (power of two, at least 4).
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port mem_a_in, input, 32 bits: CPU address bus. Only bits 17:0 are decoded.
REQ-006 SHALL have port mem_wr_in, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port mem_dout_in, input, 8 bits: CPU write data.
REQ-008 SHALL have port mem_din_out, output, 8 bits: read data returned to the CPU.
REQ-009 SHALL have port io_buffer_full_out, output, 1 bit: TX FIFO nearly full.
REQ-010 SHALL have port tx_data_out, output, 8 bits: head byte of the TX FIFO.
REQ-011 SHALL have port tx_valid_out, output, 1 bit: TX FIFO is non-empty.
REQ-012 SHALL have port tx_ready_in, input, 1 bit: UART accepts the head byte this cycle.
REQ-013 SHALL have port rx_data_in, input, 8 bits: received UART byte.
REQ-014 SHALL have port rx_valid_in, input, 1 bit: rx_data_in is valid.
REQ-015 SHALL have port rx_pop_out, output, 1 bit: one-cycle pulse that consumes the RX byte.
REQ-016 SHALL have port halt_out, output, 1 bit: sticky program-stop flag.

Function
REQ-017 SHALL decode an access as IO when mem_a_in[17:16]==2'b11, and as RAM otherwise, at index mem_a_in[RAM_ADDR_WIDTH-1:0].
REQ-018 SHALL sample address, mem_wr_in and data every cycle; a read issued in cycle N SHALL appear on the registered mem_din_out in cycle N+1.
REQ-019 SHALL perform a RAM write at the rising edge of the cycle it is presented; a RAM read of the same address in the next cycle SHALL return the new byte.
REQ-020 SHALL, on an IO write to 0x30000 with nonzero data, push the byte into the TX FIFO; 0x00 writes to 0x30000 SHALL be ignored.
REQ-021 SHALL, on an IO write to 0x30004, push 0x00 into the TX FIFO and set halt_out; halt_out SHALL stay 1 until reset, and all later writes SHALL be ignored.
REQ-022 SHALL, on an IO read of 0x30000, return rx_data_in and pulse rx_pop_out for that one cycle if rx_valid_in=1; otherwise it SHALL return 0x00 with no pop.
REQ-023 SHALL keep a 32-bit free-running cycle counter that increments every cycle after reset and wraps at 2^32.
REQ-024 SHALL, on a read of 0x30004, latch a snapshot of the counter and return its byte 0. Reads of 0x30005..0x30007 SHALL return snapshot bytes 1..3 (little-endian).
REQ-025 SHALL return 0x00 for IO reads of any other IO address, and SHALL ignore IO writes to any other IO address.
REQ-026 SHALL pop the TX FIFO when tx_valid_out and tx_ready_in are both 1; tx_data_out SHALL be the combinational head byte.
REQ-027 SHALL, when the FIFO is full, accept a push only if a pop occurs in the same cycle; otherwise the byte SHALL be dropped. A simultaneous push and pop on an empty FIFO SHALL be a push only.
REQ-028 SHALL assert io_buffer_full_out, registered, when the FIFO count is at least TX_FIFO_DEPTH-2, leaving two slots of in-flight slack.
REQ-029 SHALL implement the FIFO read and write pointers as log2(depth)+1 bits with wrap-around, so that full and empty are distinguished.

Reset
REQ-030 SHALL, while rst_in=0, asynchronously clear mem_din_out, rx_pop_out, halt_out, io_buffer_full_out, the counter, the snapshot and the FIFO pointers; tx_valid_out SHALL read 0. RAM contents are not reset.
REQ-031 SHALL, if reset is asserted mid-operation, discard all queued TX bytes and any pending read result; the first post-reset cycle is counter value 0.

Configuration
REQ-032 SHALL compile the cycle counter and snapshot in only when MEM_IO_CYCLE_CNT_EN is defined. Without it, reads of 0x30004..0x30007 SHALL return 0x00 and no counter registers SHALL exist.

Structure
REQ-033 SHALL place the IO address constants (0x30000, 0x30004), the IO decode bits [17:16], and the default widths in the shared define header.
REQ-034 SHALL implement the TX FIFO as the sub-module mem_io_tx_fifo, with push, pop, full, empty and count ports.

Verification
REQ-035 SHALL cover: write 0xA5 to 0x00100, then read 0x00100 in the next cycle -> mem_din_out=0xA5 one cycle after the read.
REQ-036 SHALL cover: writes of 0x41, 0x00, 0x42 to 0x30000 with tx_ready_in=1 -> tx_data_out delivers 0x41 then 0x42 only.
REQ-037 SHALL cover: 16 writes to 0x30000 with tx_ready_in=0 -> io_buffer_full_out=1 after the 14th push, 16 bytes held, and a 17th write is dropped.
REQ-038 SHALL cover: with rx_valid_in=1 and rx_data_in=0x37, read 0x30000 -> mem_din_out=0x37 and rx_pop_out high for exactly one cycle; with rx_valid_in=0 the read returns 0x00.
REQ-039 SHALL cover: with the macro defined, reset, wait 300 cycles, then read 0x30004..0x30007 on consecutive cycles -> the bytes form a single consistent snapshot near 300. Without the macro, all four bytes are 0x00.
REQ-040 SHALL cover: write to 0x30004 -> 0x00 is queued and halt_out=1; a later write of 0x55 to 0x00200 leaves RAM unchanged.
